// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and counter sizing.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam int unsigned DefaultWidth = 8;

   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fs_1bit.sv
// Combinational 1-bit full subtractor: diff = i0 - i1 - bin, bout is the borrow out.
module fs_1bit (
   input  logic i0,
   input  logic i1,
   input  logic bin,
   output logic diff,
   output logic bout
);

   always_comb begin
      diff = i0 ^ i1 ^ bin;
      bout = (~i0 & i1) | (~(i0 ^ i1) & bin);
   end

endmodule

// File: rtl/serial_sub_nbit.sv
// Bit-serial two's-complement subtractor: computes a - b LSB first through one
// fs_1bit cell and a registered borrow, with a start/done handshake.
module serial_sub_nbit
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_sh_q, a_sh_d;
   logic [WIDTH-1:0]  b_sh_q, b_sh_d;
   logic [WIDTH-1:0]  r_sh_q, r_sh_d;
   logic              borrow_q, borrow_d;
   logic              a_msb_q, a_msb_d;
   logic              b_msb_q, b_msb_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bout_q, bout_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic fs_diff;
   logic fs_bout;

   fs_1bit u_fs (
      .i0   (a_sh_q[0]),
      .i1   (b_sh_q[0]),
      .bin  (borrow_q),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      r_sh_d   = r_sh_q;
      borrow_d = borrow_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = StShift;
            end
         end
         StShift: begin
            // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at r_sh[0].
            r_sh_d   = {fs_diff, r_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            borrow_d = fs_bout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            diff_d  = r_sh_q;
            bout_d  = borrow_q;
            ovf_d   = (a_msb_q != b_msb_q) && (r_sh_q[WIDTH-1] != a_msb_q);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StShift);
      done_d = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         r_sh_q   <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         r_sh_q   <= r_sh_d;
         borrow_q <= borrow_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule
